// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the fetch PC, feeds PC+4 to the next-PC mux, and
// sequences boot delay, stalls and taken-branch redirects for the fetch stage.
module pc_fetch_unit #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_PC    = '0,
   parameter int unsigned      BOOT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect,
   input  logic [WIDTH-1:0] next_pc,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             if_valid,
   output logic             flush_ifid,
   output logic             misalign_err,
   output logic [15:0]      stall_count
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned SCNT_W = 16;
   localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

   localparam logic [1:0] ST_BOOT     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_STALL    = 2'd2;
   localparam logic [1:0] ST_REDIRECT = 2'd3;

   logic [1:0]        state, state_d;
   logic [CNT_W-1:0]  boot_cnt, boot_cnt_d;
   logic [WIDTH-1:0]  pc_d;
   logic              err_d;
   logic [SCNT_W-1:0] scnt_d;
   logic [WIDTH-1:0]  aligned_pc_c;
   logic              misaligned_c;

   assign pc_plus4     = pc + WIDTH'(4);
   assign aligned_pc_c = {next_pc[WIDTH-1:2], 2'b00};
   assign misaligned_c = |next_pc[1:0];

   // Next-state and next-register values; redirect always wins over stall.
   always_comb begin
      state_d    = state;
      boot_cnt_d = boot_cnt;
      pc_d       = pc;
      err_d      = misalign_err;
      scnt_d     = stall_count;
      case (state)
         ST_BOOT: begin
            boot_cnt_d = boot_cnt + CNT_W'(1);
            if (boot_cnt == BOOT_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_STALL: begin
            if (stall_count != '1) begin
               scnt_d = stall_count + SCNT_W'(1);
            end
            if (redirect) begin
               pc_d    = aligned_pc_c;
               err_d   = misalign_err | misaligned_c;
               state_d = ST_REDIRECT;
            end else if (!stall) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            if (redirect) begin
               pc_d    = aligned_pc_c;
               err_d   = misalign_err | misaligned_c;
               state_d = ST_REDIRECT;
            end else if (stall) begin
               state_d = ST_STALL;
            end else begin
               pc_d    = aligned_pc_c;
               err_d   = misalign_err | misaligned_c;
               state_d = ST_RUN;
            end
         end
      endcase
   end

   // State and output registers; fetch controls are decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_BOOT;
         boot_cnt     <= '0;
         pc           <= RESET_PC;
         misalign_err <= 1'b0;
         stall_count  <= '0;
         if_valid     <= 1'b0;
         flush_ifid   <= 1'b0;
      end else begin
         state        <= state_d;
         boot_cnt     <= boot_cnt_d;
         pc           <= pc_d;
         misalign_err <= err_d;
         stall_count  <= scnt_d;
         if_valid     <= (state_d == ST_RUN) || (state_d == ST_REDIRECT);
         flush_ifid   <= (state_d == ST_REDIRECT);
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed test-plan sequence followed by
// randomized stall/redirect/reset traffic, checked against a behavioural model.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] next_pc = '0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        if_valid;
   logic        flush_ifid;
   logic        misalign_err;
   logic [15:0] stall_count;

   pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .BOOT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .next_pc(next_pc),
      .pc(pc), .pc_plus4(pc_plus4), .if_valid(if_valid), .flush_ifid(flush_ifid),
      .misalign_err(misalign_err), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] p4;
      logic        v;
      logic        f;
      logic        e;
      logic [15:0] sc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Behavioural model: boot countdown, stalled flag, flush flag, sticky error.
   logic [31:0] m_pc = '0;
   int          m_boot = 0;
   bit          m_stalled = 0;
   bit          m_flush = 0;
   bit          m_err = 0;
   int          m_sc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit s, input bit rd, input logic [31:0] npc);
      if (r) begin
         m_pc = 32'h0; m_boot = 2; m_stalled = 0; m_flush = 0; m_err = 0; m_sc = 0;
      end else if (m_boot > 0) begin
         m_boot--;
      end else begin
         if (m_stalled && m_sc < 65535) m_sc++;
         m_flush = 0;
         if (rd) begin
            m_pc = npc & 32'hFFFF_FFFC;
            m_err = m_err | (npc[1:0] != 2'b00);
            m_flush = 1;
            m_stalled = 0;
         end else if (s) begin
            m_stalled = 1;
         end else if (m_stalled) begin
            m_stalled = 0;
         end else begin
            m_pc = npc & 32'hFFFF_FFFC;
            m_err = m_err | (npc[1:0] != 2'b00);
         end
      end
   endtask

   // One clock of stimulus; the mux feeds pc_plus4 unless redirecting.
   task automatic cyc(input bit r, input bit s, input bit rd, input logic [31:0] tgt);
      exp_t e;
      logic [31:0] npc;
      @(negedge clk);
      npc = rd ? tgt : pc_plus4;
      rst = r; stall = s; redirect = rd; next_pc = npc;
      @(posedge clk);
      model_step(r, s, rd, npc);
      e.pc = m_pc;
      e.p4 = m_pc + 32'd4;
      e.v  = (m_boot == 0) && !m_stalled;
      e.f  = m_flush;
      e.e  = m_err;
      e.sc = 16'(m_sc);
      exp_q.push_back(e);
   endtask

   // Monitor: registered outputs are compared mid-cycle against queued expectations.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("pc", pc, mon_e.pc);
         chk("pc_plus4", pc_plus4, mon_e.p4);
         chk("if_valid", 32'(if_valid), 32'(mon_e.v));
         chk("flush_ifid", 32'(flush_ifid), 32'(mon_e.f));
         chk("misalign_err", 32'(misalign_err), 32'(mon_e.e));
         chk("stall_count", 32'(stall_count), 32'(mon_e.sc));
      end
   end

   initial begin
      logic [31:0] tgt;
      bit          r, s, rd;
      // reset and boot, run to pc=8
      repeat (3) cyc(1, 0, 0, 32'h0);
      repeat (4) cyc(0, 0, 0, 32'h0);
      // stall three cycles at pc=8, then resume
      repeat (3) cyc(0, 1, 0, 32'h0);
      repeat (2) cyc(0, 0, 0, 32'h0);
      // redirect at pc=12
      cyc(0, 0, 1, 32'h0000_0100);
      repeat (2) cyc(0, 0, 0, 32'h0);
      // simultaneous stall and redirect
      cyc(0, 1, 1, 32'h0000_0200);
      cyc(0, 0, 0, 32'h0);
      // back-to-back redirects, the second misaligned
      cyc(0, 0, 1, 32'h0000_0300);
      cyc(0, 0, 1, 32'h0000_0203);
      repeat (2) cyc(0, 0, 0, 32'h0);
      // redirect out of STALL
      repeat (2) cyc(0, 1, 0, 32'h0);
      cyc(0, 1, 1, 32'h0000_0500);
      cyc(0, 0, 0, 32'h0);
      // wrap-around
      cyc(0, 0, 1, 32'hFFFF_FFFC);
      repeat (2) cyc(0, 0, 0, 32'h0);
      // reset during REDIRECT, inputs active during reset and boot
      repeat (2) cyc(0, 1, 0, 32'h0);
      cyc(0, 0, 1, 32'h0000_0601);
      cyc(1, 1, 1, 32'h0000_0700);
      cyc(0, 1, 1, 32'h0000_0800);
      cyc(0, 1, 1, 32'h0000_0900);
      repeat (3) cyc(0, 0, 0, 32'h0);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(59) == 0);
         s  = ($urandom_range(99) < 35);
         rd = ($urandom_range(99) < 20);
         tgt = $urandom;
         if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
         if ($urandom_range(9) == 0) tgt = 32'hFFFF_FFF8;
         cyc(r, s, rd, tgt);
      end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

- Program-counter stage of the pipelined processor.
- Holds the architectural PC and drives the 2:1 next-PC select mux's A input with PC+4.
- Registers the mux output as the new PC on each clock edge.
- Handles boot delay, pipeline stalls and taken-branch redirects, and produces the fetch-valid and IF/ID-flush controls for the fetch stage.

## Interface
- WIDTH, 32, address width in bits.
- RESET_PC, 32'h0000_0000, PC value after reset.
- BOOT_CYCLES, 2, cycles after reset before the first fetch is valid (instruction memory warm-up); legal range 1-15.
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit requests PC hold.
- redirect  input  1  mux select (branch/jump taken); same signal that drives the mux sel.
- next_pc  input  WIDTH  mux output (A=pc_plus4 when redirect=0, B=branch target when redirect=1).
- pc  output  WIDTH  current fetch address.
- pc_plus4  output  WIDTH  pc+4, combinational, feeds mux input A.
- if_valid  output  1  the instruction fetched at pc this cycle is a new, valid instruction.
- flush_ifid  output  1  one-cycle pulse: squash the IF/ID register contents.
- misalign_err  output  1  sticky: a next_pc with bits [1:0] != 0 was accepted.
- stall_count  output  16  saturating count of cycles spent in STALL.

## Operation
- States: BOOT, RUN, STALL, REDIRECT. A 4-bit boot counter is used in BOOT.
- Reset (rst=1 at an edge):
  - pc=RESET_PC; state=BOOT; boot counter=0.
  - if_valid=0, flush_ifid=0, misalign_err=0, stall_count=0.
  - pc_plus4 follows as RESET_PC+4.
- BOOT:
  - pc held; if_valid=0.
  - stall and redirect are ignored.
  - The counter increments each cycle. When it reaches BOOT_CYCLES-1, go to RUN.
- RUN / REDIRECT, per edge, in priority order:
  1. redirect=1:
     - pc<=next_pc with bits [1:0] forced to 00.
     - misalign_err set if the original next_pc[1:0] != 0.
     - Go to REDIRECT. Redirect overrides a simultaneous stall.
  2. stall=1: pc held; go to STALL.
  3. Otherwise: pc<=next_pc (bits [1:0] forced to 00, misalign check applied); go to RUN.
- STALL:
  - pc held.
  - stall_count increments each cycle in STALL, saturating at 16'hFFFF.
  - redirect=1: behave as rule 1 above (go to REDIRECT).
  - stall=0: go to RUN without updating pc. The held instruction is re-presented as valid.
  - stall=1: remain in STALL.
- REDIRECT: lasts exactly one cycle, then follows the RUN rules.
- Arithmetic: pc_plus4 = pc + 4, modulo 2^WIDTH. 32'hFFFF_FFFC + 4 wraps to 0; no error is raised.

## Timing
- if_valid = 1 in RUN and REDIRECT; 0 in BOOT and STALL. It is registered (decoded from state).
- flush_ifid = 1 only in REDIRECT, i.e. exactly the cycle after the edge that accepted the redirect. Back-to-back redirects produce back-to-back flush cycles.
- Latency:
  - next_pc sampled at edge N appears on pc after edge N.
  - pc_plus4 is valid in the same cycle as pc.
- First valid fetch: cycle BOOT_CYCLES after reset deassertion. With the default of 2, if_valid rises on the 2nd edge after rst falls.
- rst mid-operation (any state, including REDIRECT or STALL):
  - All outputs return to reset values after that edge.
  - A pending flush pulse is dropped.
  - stall_count clears.
- stall and redirect are don't-care during BOOT and during rst.

## Test plan
- Reset/boot:
  - Stimulus: rst high 3 cycles, then low; stall=0, redirect=0; mux feeds pc_plus4.
  - Required: pc=0 with if_valid=0 for 2 cycles. Then pc sequences 0, 4, 8, 12 with if_valid=1, and flush_ifid stays 0.
- Stall:
  - Stimulus: in RUN at pc=8, assert stall for 3 cycles.
  - Required: pc holds 8 and if_valid=0 for 3 cycles; stall_count=3. Then pc=8 is valid again, followed by 12.
- Redirect:
  - Stimulus: at pc=12, redirect=1, next_pc=32'h0000_0100.
  - Required: the next cycle has pc=0x100 with flush_ifid=1 for exactly 1 cycle, followed by pc=0x104.
- Simultaneous events:
  - Stimulus: stall=1 and redirect=1 on the same cycle (target 0x200).
  - Required: pc=0x200 and flush_ifid=1; stall_count does not increment.
- Misalignment and wrap-around:
  - Stimulus 1: redirect to 0x203.
  - Required: pc=0x200 and misalign_err=1, remaining set until reset.
  - Stimulus 2: run from pc=0xFFFF_FFFC.
  - Required: pc_plus4=0, and the next pc is 0.
- Mid-operation reset:
  - Stimulus: assert rst during REDIRECT.
  - Required: next cycle pc=0, flush_ifid=0, misalign_err=0, stall_count=0, state BOOT.
